// File: rtl/wb_simple_master_pkg.sv
// rtl/wb_simple_master_pkg.sv - shared status codes and FSM encoding for wb_simple_master
// Contents:
//   ST_OK/ST_ERR/ST_RTY/ST_TMO : 2-bit completion status reported on status_o
//   state_t                    : master FSM state encoding (IDLE=0, STROBE=1, WAIT=2, RETRY=3)
package wb_simple_master_pkg;

  localparam logic [1:0] ST_OK  = 2'b00;
  localparam logic [1:0] ST_ERR = 2'b01;
  localparam logic [1:0] ST_RTY = 2'b10;
  localparam logic [1:0] ST_TMO = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STROBE = 2'd1,
    S_WAIT   = 2'd2,
    S_RETRY  = 2'd3
  } state_t;

endpackage

// File: rtl/wb_simple_master_tmo.sv
// rtl/wb_simple_master_tmo.sv - 16-bit bus-cycle timeout counter
// Ports:
//   clk_i      in   clock
//   rst_n_i    in   asynchronous active-low reset
//   clr_i      in   clear count to zero (wins over en_i)
//   en_i       in   count one cycle
//   expired_o  out  count has reached TIMEOUT-1
module wb_simple_master_tmo #(
  parameter int TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [15:0] LAST = 16'(TIMEOUT - 1);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  // Saturating at LAST keeps expired_o asserted instead of wrapping if the
  // owner is slow to react.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LAST)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == LAST);

endmodule

// File: rtl/wb_simple_master.sv
// rtl/wb_simple_master.sv - single-request Wishbone pipelined master with retry and timeout
// Ports:
//   clk_i, rst_n_i                     clock, asynchronous active-low reset
//   req_i, we_i, adr_i, dat_i, sel_i   local request (sampled only while busy_o=0)
//   busy_o, done_o, status_o, rdat_o   local completion side (status/rdat held between dones)
//   wb_cyc_o, wb_stb_o, wb_we_o        Wishbone controls
//   wb_adr_o, wb_sel_o, wb_dat_o       Wishbone address, byte selects, write data
//   wb_ack_i, wb_err_i, wb_rty_i       Wishbone terminating responses
//   wb_stall_i, wb_dat_i               Wishbone stall and read data
module wb_simple_master
  import wb_simple_master_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255,
  parameter int MAX_RETRY  = 3
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    req_i,
  input  logic                    we_i,
  input  logic [ADDR_WIDTH-1:0]   adr_i,
  input  logic [DATA_WIDTH-1:0]   dat_i,
  input  logic [DATA_WIDTH/8-1:0] sel_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [1:0]              status_o,
  output logic [DATA_WIDTH-1:0]   rdat_o,
  output logic                    wb_cyc_o,
  output logic                    wb_stb_o,
  output logic                    wb_we_o,
  output logic [ADDR_WIDTH-1:0]   wb_adr_o,
  output logic [DATA_WIDTH/8-1:0] wb_sel_o,
  output logic [DATA_WIDTH-1:0]   wb_dat_o,
  input  logic                    wb_ack_i,
  input  logic                    wb_err_i,
  input  logic                    wb_rty_i,
  input  logic                    wb_stall_i,
  input  logic [DATA_WIDTH-1:0]   wb_dat_i
);

  localparam int RW = $clog2(MAX_RETRY + 2);
  localparam logic [RW-1:0] MAX_RETRY_C = RW'(MAX_RETRY);

  state_t                  state_q, state_d;
  logic                    cyc_q, cyc_d;
  logic                    stb_q, stb_d;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   adr_q, adr_d;
  logic [DATA_WIDTH-1:0]   dat_q, dat_d;
  logic [DATA_WIDTH/8-1:0] sel_q, sel_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [1:0]              status_q, status_d;
  logic [DATA_WIDTH-1:0]   rdat_q, rdat_d;
  logic [RW-1:0]           retry_q, retry_d;

  logic       tmo_clr;
  logic       tmo_expired;
  logic       resp_phase;
  logic       finish;
  logic [1:0] fin_status;

  wb_simple_master_tmo #(
    .TIMEOUT (TIMEOUT)
  ) u_tmo (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .clr_i     (tmo_clr),
    .en_i      (cyc_q),
    .expired_o (tmo_expired)
  );

  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    stb_d      = stb_q;
    we_d       = we_q;
    adr_d      = adr_q;
    dat_d      = dat_q;
    sel_d      = sel_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    status_d   = status_q;
    rdat_d     = rdat_q;
    retry_d    = retry_q;
    tmo_clr    = 1'b0;
    finish     = 1'b0;
    fin_status = ST_OK;

    // The slave may terminate in the very cycle it accepts the strobe
    // (it drops stall together with ack), so acceptance doubles as a
    // response sampling point.
    resp_phase = (state_q == S_WAIT) || ((state_q == S_STROBE) && !wb_stall_i);

    case (state_q)
      S_IDLE: begin
        if (req_i) begin
          we_d    = we_i;
          adr_d   = adr_i;
          dat_d   = dat_i;
          sel_d   = sel_i;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          busy_d  = 1'b1;
          retry_d = '0;
          tmo_clr = 1'b1;
          state_d = S_STROBE;
        end
      end
      S_STROBE: begin
        if (!wb_stall_i) begin
          stb_d   = 1'b0;
          state_d = S_WAIT;
        end
      end
      S_RETRY: begin
        stb_d   = 1'b1;
        state_d = S_STROBE;
      end
      default: begin
      end
    endcase

    if (resp_phase) begin
      if (wb_err_i) begin
        finish     = 1'b1;
        fin_status = ST_ERR;
      end else if (wb_ack_i) begin
        finish     = 1'b1;
        fin_status = ST_OK;
        if (!we_q) begin
          rdat_d = wb_dat_i;
        end
      end else if (wb_rty_i) begin
        if (retry_q < MAX_RETRY_C) begin
          retry_d = retry_q + 1'b1;
          stb_d   = 1'b0;
          state_d = S_RETRY;
        end else begin
          finish     = 1'b1;
          fin_status = ST_RTY;
        end
      end
    end

    // A retry-able rty is not terminating, so the timeout still wins over it.
    if (!finish && (state_q != S_IDLE) && tmo_expired) begin
      finish     = 1'b1;
      fin_status = ST_TMO;
    end

    if (finish) begin
      cyc_d    = 1'b0;
      stb_d    = 1'b0;
      busy_d   = 1'b0;
      done_d   = 1'b1;
      status_d = fin_status;
      state_d  = S_IDLE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= S_IDLE;
      cyc_q    <= 1'b0;
      stb_q    <= 1'b0;
      we_q     <= 1'b0;
      adr_q    <= '0;
      dat_q    <= '0;
      sel_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      status_q <= ST_OK;
      rdat_q   <= '0;
      retry_q  <= '0;
    end else begin
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      stb_q    <= stb_d;
      we_q     <= we_d;
      adr_q    <= adr_d;
      dat_q    <= dat_d;
      sel_q    <= sel_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      status_q <= status_d;
      rdat_q   <= rdat_d;
      retry_q  <= retry_d;
    end
  end

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign status_o = status_q;
  assign rdat_o   = rdat_q;
  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = stb_q;
  assign wb_we_o  = we_q;
  assign wb_adr_o = adr_q;
  assign wb_sel_o = sel_q;
  assign wb_dat_o = dat_q;

endmodule
